// File: rtl/fetch_redirect_unit_pkg.sv
// Shared types for the fetch stage: FSM state encodings, the IF/ID entry layout and the bubble encoding.
package fetch_redirect_unit_pkg;

  typedef enum logic [1:0] {
    FETCH_ISSUE = 2'd0,
    FETCH_WAIT  = 2'd1,
    FETCH_HOLD  = 2'd2,
    FETCH_DROP  = 2'd3
  } fetch_state_e;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_redirect_unit_if.sv
// Instruction-memory read port: one-cycle request pulse, response valid for one cycle some cycles later.
interface fetch_redirect_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;

  modport master (output imem_req, imem_addr, input imem_rdata, imem_valid);
  modport slave  (input imem_req, imem_addr, output imem_rdata, imem_valid);
endinterface

// File: rtl/fetch_redirect_unit_if_id_reg.sv
// IF/ID pipeline register; priority flush > hold > load > bubble, one cycle from control to output.
module fetch_redirect_unit_if_id_reg
  import fetch_redirect_unit_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         hold,
  input  logic         load,
  input  fetch_entry_t load_dat,
  output logic [31:0]  pc,
  output logic [31:0]  instr,
  output logic         valid
);

  fetch_entry_t entry_d, entry_q;
  logic         valid_d, valid_q;

  always_comb begin
    entry_d = '{pc: 32'd0, instr: NOP_INSTR};
    valid_d = 1'b0;
    if (flush) begin
      entry_d = '{pc: 32'd0, instr: NOP_INSTR};
      valid_d = 1'b0;
    end else if (hold) begin
      entry_d = entry_q;
      valid_d = valid_q;
    end else if (load) begin
      entry_d = load_dat;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entry_q <= '{pc: 32'd0, instr: NOP_INSTR};
      valid_q <= 1'b0;
    end else begin
      entry_q <= entry_d;
      valid_q <= valid_d;
    end
  end

  assign pc    = entry_q.pc;
  assign instr = entry_q.instr;
  assign valid = valid_q;

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch stage: PC, one-outstanding imem request FSM, one-entry hold buffer and IF/ID register.
// Best case one instruction into IF/ID every 2 cycles; stall freezes IF/ID and parks a late response in HOLD.
module fetch_redirect_unit
  import fetch_redirect_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall,
  input  logic                         branch_comp,
  input  logic [31:0]                  branch_target,
  input  logic                         is_jump,
  input  logic [31:0]                  jump_target,
  fetch_redirect_unit_if.master        imem,
  output logic [31:0]                  if_id_pc,
  output logic [31:0]                  if_id_instr,
  output logic                         if_id_valid
);

  fetch_state_e state_d, state_q;
  logic [31:0]  pc_d, pc_q;
  // Buffer contents are meaningful only while in HOLD; the state doubles as its occupancy flag.
  fetch_entry_t buf_d, buf_q;

  logic         redirect;
  logic [31:0]  target;
  logic         avail;
  fetch_entry_t load_dat;

  assign redirect = !stall && (branch_comp || is_jump);
  assign target   = align_word(is_jump ? jump_target : branch_target);
  assign avail    = ((state_q == FETCH_WAIT) && imem.imem_valid) || (state_q == FETCH_HOLD);
  assign load_dat = (state_q == FETCH_HOLD) ? buf_q : '{pc: pc_q, instr: imem.imem_rdata};

  assign imem.imem_req  = (state_q == FETCH_ISSUE) && !redirect && rst_n;
  assign imem.imem_addr = pc_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    unique case (state_q)
      FETCH_ISSUE: begin
        if (redirect) pc_d = target;
        else          state_d = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (imem.imem_valid) begin
          if (redirect) begin
            pc_d    = target;
            state_d = FETCH_ISSUE;
          end else if (!stall) begin
            pc_d    = pc_q + 32'd4;
            state_d = FETCH_ISSUE;
          end else begin
            buf_d   = '{pc: pc_q, instr: imem.imem_rdata};
            pc_d    = pc_q + 32'd4;
            state_d = FETCH_HOLD;
          end
        end else if (redirect) begin
          pc_d    = target;
          state_d = FETCH_DROP;
        end
      end
      FETCH_HOLD: begin
        if (redirect) begin
          pc_d    = target;
          state_d = FETCH_ISSUE;
        end else if (!stall) begin
          state_d = FETCH_ISSUE;
        end
      end
      FETCH_DROP: begin
        // The wrong-path response still has to drain before a new request may go out.
        if (redirect)         pc_d    = target;
        if (imem.imem_valid)  state_d = FETCH_ISSUE;
      end
      default: state_d = FETCH_ISSUE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH_ISSUE;
      pc_q    <= RESET_PC;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
    end
  end

  fetch_redirect_unit_if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect),
    .hold     (stall),
    .load     (avail),
    .load_dat (load_dat),
    .pc       (if_id_pc),
    .instr    (if_id_instr),
    .valid    (if_id_valid)
  );

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit with a latency-programmable memory model and an IF/ID scoreboard.
module tb_fetch_redirect_unit;
  import fetch_redirect_unit_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch_comp;
  logic [31:0] branch_target;
  logic        is_jump;
  logic [31:0] jump_target;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;

  fetch_redirect_unit_if imem_if ();

  fetch_redirect_unit #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_comp   (branch_comp),
    .branch_target (branch_target),
    .is_jump       (is_jump),
    .jump_target   (jump_target),
    .imem          (imem_if),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr),
    .if_id_valid   (if_id_valid)
  );

  always #5 clk = ~clk;

  int           checks   = 0;
  int           failures = 0;
  int           mem_lat  = 1;
  fetch_entry_t exp_q[$];
  logic         prev_v;
  logic [31:0]  prev_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'd0) return 32'h00A0_0093;
    return {a[23:0], 8'h13} ^ 32'h0010_0000;
  endfunction

  // Memory: a request seen at negedge is answered mem_lat cycles later for exactly one cycle.
  initial begin : mem_model
    logic        pend;
    logic [31:0] pend_addr;
    int          pend_cnt;
    pend      = 1'b0;
    pend_addr = 32'd0;
    pend_cnt  = 0;
    imem_if.imem_valid = 1'b0;
    imem_if.imem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (imem_if.imem_req === 1'b1) begin
        pend      = 1'b1;
        pend_addr = imem_if.imem_addr;
        pend_cnt  = mem_lat;
      end
      @(posedge clk);
      #1;
      imem_if.imem_valid = 1'b0;
      if (pend) begin
        pend_cnt = pend_cnt - 1;
        if (pend_cnt == 0) begin
          imem_if.imem_valid = 1'b1;
          imem_if.imem_rdata = mem_word(pend_addr);
          pend = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every fresh valid IF/ID entry must match the head of the expected queue.
  task automatic sb_sample();
    fetch_entry_t e;
    if (if_id_valid === 1'b1 && !(prev_v === 1'b1 && prev_pc === if_id_pc)) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL sb_unexpected observed=%h/%h expected=none", if_id_pc, if_id_instr);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_pc", if_id_pc, e.pc);
        chk("sb_instr", if_id_instr, e.instr);
      end
    end
    prev_v  = if_id_valid;
    prev_pc = if_id_pc;
  endtask

  task automatic push(input logic [31:0] a);
    exp_q.push_back('{pc: a, instr: mem_word(a)});
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    sb_sample();
  endtask

  initial begin : stim
    prev_v        = 1'b0;
    prev_pc       = 32'd0;
    rst_n         = 1'b0;
    stall         = 1'b0;
    branch_comp   = 1'b0;
    branch_target = 32'd0;
    is_jump       = 1'b0;
    jump_target   = 32'd0;
    tick();
    tick();
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst_instr", if_id_instr, NOP);
    chk("rst_pc", if_id_pc, 32'd0);
    chk("rst_req", {31'd0, imem_if.imem_req}, 32'd0);

    // Straight-line fetch of 0,4,8,C with 1-cycle memory.
    rst_n = 1'b1;
    #1;
    chk("first_req", {31'd0, imem_if.imem_req}, 32'd1);
    chk("first_addr", imem_if.imem_addr, 32'd0);
    for (int i = 0; i < 4; i++) push(32'(4 * i));
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      chk("wait_req", {31'd0, imem_if.imem_req}, 32'd0);
      chk("wait_bubble", {31'd0, if_id_valid}, 32'd0);
      tick(); #1;
      chk("line_pc", if_id_pc, 32'(4 * i));
      chk("line_instr", if_id_instr, mem_word(32'(4 * i)));
      chk("line_valid", {31'd0, if_id_valid}, 32'd1);
      chk("next_req", {31'd0, imem_if.imem_req}, 32'd1);
      chk("next_addr", imem_if.imem_addr, 32'(4 * (i + 1)));
    end

    // Reset while the request for 0x10 is outstanding; its response lands in ISSUE.
    mem_lat = 2;
    tick();
    rst_n = 1'b0; #1;
    chk("rstmid_req", {31'd0, imem_if.imem_req}, 32'd0);
    tick();
    rst_n = 1'b1;
    mem_lat = 1;
    #1;
    chk("rstmid_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rstmid_req2", {31'd0, imem_if.imem_req}, 32'd1);
    chk("rstmid_addr", imem_if.imem_addr, 32'd0);
    push(32'd0); push(32'd4); push(32'd8);
    tick(); #1;
    chk("late_ignored", {31'd0, if_id_valid}, 32'd0);
    tick(); tick(); tick(); #1;
    chk("pre_stall_pc", if_id_pc, 32'd4);
    chk("pre_stall_addr", imem_if.imem_addr, 32'd8);

    // Stall across the arrival of the response for pc=8.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk("stall_pc", if_id_pc, 32'd4);
      chk("stall_valid", {31'd0, if_id_valid}, 32'd1);
      chk("stall_req", {31'd0, imem_if.imem_req}, 32'd0);
    end
    stall = 1'b0;
    tick(); #1;
    chk("unstall_pc", if_id_pc, 32'd8);
    chk("unstall_instr", if_id_instr, mem_word(32'd8));
    chk("unstall_addr", imem_if.imem_addr, 32'hC);

    // Taken branch while in ISSUE.
    branch_comp = 1'b1; branch_target = 32'h40; #1;
    chk("br_req", {31'd0, imem_if.imem_req}, 32'd0);
    tick();
    branch_comp = 1'b0; #1;
    chk("br_flush_valid", {31'd0, if_id_valid}, 32'd0);
    chk("br_flush_instr", if_id_instr, NOP);
    chk("br_req2", {31'd0, imem_if.imem_req}, 32'd1);
    chk("br_addr", imem_if.imem_addr, 32'h40);

    // Jump while waiting on a 3-cycle response: it must be dropped.
    mem_lat = 3;
    tick();
    is_jump = 1'b1; jump_target = 32'h101; #1;
    chk("jmp_wait_req", {31'd0, imem_if.imem_req}, 32'd0);
    tick();
    is_jump = 1'b0; #1;
    chk("drop_req", {31'd0, imem_if.imem_req}, 32'd0);
    chk("drop_valid", {31'd0, if_id_valid}, 32'd0);
    tick(); #1;
    chk("drop_req2", {31'd0, imem_if.imem_req}, 32'd0);
    tick(); #1;
    chk("jmp_req", {31'd0, imem_if.imem_req}, 32'd1);
    chk("jmp_addr", imem_if.imem_addr, 32'h100);
    chk("jmp_valid", {31'd0, if_id_valid}, 32'd0);
    mem_lat = 1;
    push(32'h100);
    tick(); tick(); #1;
    chk("jmp_pc", if_id_pc, 32'h100);
    chk("jmp_next_addr", imem_if.imem_addr, 32'h104);

    // Branch under stall is ignored until stall drops.
    stall = 1'b1; branch_comp = 1'b1; branch_target = 32'h203; #1;
    chk("brst_req", {31'd0, imem_if.imem_req}, 32'd1);
    chk("brst_addr", imem_if.imem_addr, 32'h104);
    tick(); #1;
    chk("brst_hold_pc", if_id_pc, 32'h100);
    chk("brst_hold_valid", {31'd0, if_id_valid}, 32'd1);
    chk("brst_pc_same", imem_if.imem_addr, 32'h104);
    stall = 1'b0;
    tick();
    branch_comp = 1'b0; #1;
    chk("brst_flush", {31'd0, if_id_valid}, 32'd0);
    chk("brst_addr2", imem_if.imem_addr, 32'h200);
    chk("brst_req2", {31'd0, imem_if.imem_req}, 32'd1);
    push(32'h200);
    tick(); tick(); #1;
    chk("brst_pc", if_id_pc, 32'h200);

    // PC wrap from the top word back to 0.
    is_jump = 1'b1; jump_target = 32'hFFFF_FFFE; #1;
    tick();
    is_jump = 1'b0; #1;
    chk("wrap_addr", imem_if.imem_addr, 32'hFFFF_FFFC);
    push(32'hFFFF_FFFC); push(32'd0);
    tick(); tick(); #1;
    chk("wrap_pc", if_id_pc, 32'hFFFF_FFFC);
    chk("wrap_next", imem_if.imem_addr, 32'd0);
    tick(); tick(); #1;
    chk("wrap_instr", if_id_instr, 32'h00A0_0093);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
